pwm_ciclo_multicanal: RTL and testbench
=======================================

PWM_CICLO_MULTICANAL -- requirements
Module: pwm_ciclo_multicanal

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent PWM channels (1..16).
REQ-002 SHALL have parameter DUTY_W, default 4, duty register width; period P = 2^DUTY_W - 1 ticks.
REQ-003 SHALL have parameter PRESCALE, default 1, clk_100MHz cycles per PWM tick (>=1).
REQ-004 SHALL have parameter STEP, default 1, duty increment/decrement per accepted button edge (1..P).
REQ-005 SHALL have port clk_100MHz  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port up  input  1  asynchronous increase request, level; rising edge is the event.
REQ-008 SHALL have port down  input  1  asynchronous decrease request, level; rising edge is the event.
REQ-009 SHALL have port ch_sel  input  max(1,clog2(N_CH))  channel targeted by up/down and shown on duty_actual.
REQ-010 SHALL have port chip_select  input  1  enable for up/down edges; low = edges discarded.
REQ-011 SHALL have port wrap_mode  input  1  0 = saturate at 0/P, 1 = wrap modulo P+1.
REQ-012 SHALL have port pwm_out  output  N_CH  registered PWM output per channel.
REQ-013 SHALL have port duty_actual  output  DUTY_W  pending duty register of channel ch_sel.
REQ-014 SHALL have port period_start  output  1  one-cycle pulse on the cycle the tick counter restarts at 0.

Function
REQ-015 up and down SHALL each pass through a 2-flop synchronizer plus one history flop; event = sync_out & ~history.
REQ-016 An input rising before clock edge k SHALL change duty_reg at edge k+2 (3rd edge) and duty_actual the same cycle.
REQ-017 Up and down events in the same cycle SHALL both be discarded; duty_reg unchanged.
REQ-018 Events while chip_select=0, or with ch_sel >= N_CH, SHALL be discarded.
REQ-019 Increment, wrap_mode=0: duty_reg = min(duty_reg+STEP, P); decrement: max(duty_reg-STEP, 0); no overflow of internal width.
REQ-020 Increment, wrap_mode=1: duty_reg = (duty_reg+STEP) mod (P+1); decrement: (duty_reg-STEP) mod (P+1).
REQ-021 A prescaler SHALL assert a tick every PRESCALE cycles (every cycle when PRESCALE=1), counting 0..PRESCALE-1.
REQ-022 A shared tick counter cnt SHALL advance on each tick 0,1,...,P-1, then return to 0.
REQ-023 period_start SHALL be high exactly for the cycle where a tick moves cnt from P-1 to 0.
REQ-024 Each channel SHALL hold duty_active (shadow), loaded from duty_reg only on period_start; mid-period changes never glitch the output.
REQ-025 pwm_out[i] SHALL be registered: 1 when cnt < duty_active[i], else 0; duty 0 = always low, duty P = always high.
REQ-026 Channels SHALL be fully independent; an event on channel i SHALL not alter any other channel.
REQ-027 duty_actual SHALL show duty_reg (not duty_active) of ch_sel; 0 when ch_sel >= N_CH.

Reset
REQ-028 rst=1 at a rising edge SHALL clear all duty_reg, duty_active, cnt, prescaler, synchronizer and history flops on that edge.
REQ-029 During and after reset pwm_out=0, duty_actual=0, period_start=0; first period_start 15 ticks after rst release (defaults).
REQ-030 Reset mid-period SHALL abort the period; an up/down edge in flight when rst asserts SHALL be lost.
REQ-031 An input held high through reset release SHALL NOT generate an event (history cleared to 0 is reloaded before compare only if sync path sees a new rise); bench treats a high level at release as no event.

Verification (N_CH=4, DUTY_W=4, P=15, PRESCALE=1, STEP=1)
REQ-032 Reset, ch_sel=2, chip_select=1, 5 up pulses -> duty_actual=5; after next period_start pwm_out[2] high 5 of every 15 cycles; others 0.
REQ-033 wrap_mode=0, 20 up pulses on ch 0 -> duty_actual=15, pwm_out[0] constantly 1; 1 down -> 14.
REQ-034 wrap_mode=1, duty=15, 1 up -> 0; 1 down -> 15.
REQ-035 up and down rising same cycle, or chip_select=0 during pulse -> duty_actual unchanged.
REQ-036 Change duty 3->10 at cnt=5 -> current period keeps 3-cycle high; 10-cycle high from next period_start.
REQ-037 PRESCALE=4 build: period_start every 60 cycles; rst asserted mid-period -> all outputs 0 next edge, cnt restarts.

Source files
------------

// File: rtl/pwm_ciclo_multicanal.sv
// Multi-channel PWM generator with button-driven duty adjustment per channel.
// Shared prescaler/tick counter; each channel shadows its duty at period start.
module pwm_ciclo_multicanal #(
  parameter int N_CH     = 4,
  parameter int DUTY_W   = 4,
  parameter int PRESCALE = 1,
  parameter int STEP     = 1,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              chip_select,
  input  logic              wrap_mode,
  output logic [N_CH-1:0]   pwm_out,
  output logic [DUTY_W-1:0] duty_actual,
  output logic              period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] P_MAX    = '1;
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);
  localparam logic [DUTY_W:0]   STEP_EXT = (DUTY_W + 1)'(STEP);

  logic [1:0]        up_sync, down_sync;
  logic              up_hist, down_hist;
  logic [1:0]        arm_cnt;
  logic              armed, up_ev, down_ev, accept;
  logic [PRE_W-1:0]  pre;
  logic [DUTY_W-1:0] cnt;
  logic              tick, period_wrap;
  logic [DUTY_W-1:0] duty_reg    [N_CH];
  logic [DUTY_W-1:0] duty_active [N_CH];

  // One extra bit of headroom so saturation never sees a wrapped sum.
  function automatic logic [DUTY_W-1:0] next_duty(input logic [DUTY_W-1:0] cur,
                                                  input logic inc, input logic wrap);
    logic [DUTY_W:0] sum, diff;
    sum  = {1'b0, cur} + STEP_EXT;
    diff = {1'b0, cur} - STEP_EXT;
    if (inc) next_duty = (wrap || sum <= {1'b0, P_MAX}) ? sum[DUTY_W-1:0] : P_MAX;
    else     next_duty = (wrap || !diff[DUTY_W]) ? diff[DUTY_W-1:0] : '0;
  endfunction

  // Edges are ignored until the synchronizer pipeline has refilled after reset,
  // so a level already high at release is absorbed into the history flop.
  always_ff @(posedge clk_100MHz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      up_sync   <= '0;
      down_sync <= '0;
      up_hist   <= 1'b0;
      down_hist <= 1'b0;
      arm_cnt   <= '0;
    end else begin
      up_sync   <= {up_sync[0], up};
      down_sync <= {down_sync[0], down};
      up_hist   <= up_sync[1];
      down_hist <= down_sync[1];
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed       = (arm_cnt == 2'd3);
  assign up_ev       = armed & up_sync[1] & ~up_hist;
  assign down_ev     = armed & down_sync[1] & ~down_hist;
  assign accept      = chip_select & (up_ev ^ down_ev);
  assign tick        = (pre == PRE_LAST);
  assign period_wrap = tick & (cnt == CNT_LAST);

  always_ff @(posedge clk_100MHz) begin
    // NOTE: the duty arrays are reset because outputs must read zero right after reset.
    if (rst) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_reg[i]    <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= period_wrap ? '0 : cnt + 1'b1;
      period_start <= period_wrap;
      for (int i = 0; i < N_CH; i++) begin
        if (accept && ch_sel == SEL_W'(i))
          duty_reg[i] <= next_duty(duty_reg[i], up_ev, wrap_mode);
        if (period_wrap) duty_active[i] <= duty_reg[i];
        pwm_out[i] <= (cnt < duty_active[i]);
      end
    end
  end

  // Unmapped selector values fall through to zero.
  always_comb begin
    // NOTE: default assigned first so no path leaves duty_actual unassigned (no latch).
    duty_actual = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch_sel == SEL_W'(i)) duty_actual = duty_reg[i];
  end

endmodule

// File: tb/tb_pwm_ciclo_multicanal.sv
// Directed bench for pwm_ciclo_multicanal: default build plus a PRESCALE=4 build.
module tb_pwm_ciclo_multicanal;

  logic       clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;

  logic       rst, up, down, chip_select, wrap_mode;
  logic [1:0] ch_sel;
  logic [3:0] pwm_out, duty_actual;
  logic       period_start;

  logic       rst4, up4, down4, chip_select4, wrap_mode4;
  logic [1:0] ch_sel4;
  logic [3:0] pwm_out4, duty_actual4;
  logic       period_start4;

  pwm_ciclo_multicanal dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .up(up), .down(down), .ch_sel(ch_sel),
    .chip_select(chip_select), .wrap_mode(wrap_mode), .pwm_out(pwm_out),
    .duty_actual(duty_actual), .period_start(period_start)
  );

  pwm_ciclo_multicanal #(.PRESCALE(4)) dut4 (
    .clk_100MHz(clk_100MHz), .rst(rst4), .up(up4), .down(down4), .ch_sel(ch_sel4),
    .chip_select(chip_select4), .wrap_mode(wrap_mode4), .pwm_out(pwm_out4),
    .duty_actual(duty_actual4), .period_start(period_start4)
  );

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic pulse(input logic do_up, input logic do_down);
    up = do_up; down = do_down;
    tick_n(2);
    up = 1'b0; down = 1'b0;
    tick_n(3);
  endtask

  task automatic pulse4_up();
    up4 = 1'b1; tick_n(2);
    up4 = 1'b0; tick_n(3);
  endtask

  // Returns cycles waited until period_start is seen, or -1 if the budget expires.
  task automatic wait_ps(input int budget, output int waited);
    waited = 0;
    do begin @(negedge clk_100MHz); waited++; end
    while (period_start !== 1'b1 && waited < budget);
    if (period_start !== 1'b1) waited = -1;
  endtask

  task automatic wait_ps4(input int budget, output int waited);
    waited = 0;
    do begin @(negedge clk_100MHz); waited++; end
    while (period_start4 !== 1'b1 && waited < budget);
    if (period_start4 !== 1'b1) waited = -1;
  endtask

  task automatic test_reset();
    int w;
    int bad_pwm;
    rst = 1'b1; rst4 = 1'b1;
    up = 1'b1; down = 1'b0; ch_sel = 2'd0; chip_select = 1'b1; wrap_mode = 1'b0;
    up4 = 1'b0; down4 = 1'b0; ch_sel4 = 2'd0; chip_select4 = 1'b1; wrap_mode4 = 1'b0;
    tick_n(3);
    checks++;
    if ({pwm_out, duty_actual, period_start} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pwm=%b duty=%0d ps=%b, expected all 0", pwm_out, duty_actual, period_start);
    end
    checks++;
    if ({pwm_out4, duty_actual4, period_start4} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs_p4: got pwm=%b duty=%0d ps=%b, expected all 0", pwm_out4, duty_actual4, period_start4);
    end
    // up stays high across the release; it must not count as an edge.
    rst = 1'b0; rst4 = 1'b0;
    w = 0; bad_pwm = 0;
    do begin
      @(negedge clk_100MHz); w++;
      if (pwm_out !== 4'd0) bad_pwm++;
    end while (period_start !== 1'b1 && w < 40);
    checks++;
    if (w !== 15) begin
      errors++;
      $display("FAIL first_period_start: got %0d cycles, expected 15", w);
    end
    checks++;
    if (bad_pwm !== 0) begin
      errors++;
      $display("FAIL pwm_after_reset: got %0d nonzero samples, expected 0", bad_pwm);
    end
    up = 1'b0;
    tick_n(3);
    checks++;
    if (duty_actual !== 4'd0) begin
      errors++;
      $display("FAIL held_up_at_release: got duty %0d, expected 0", duty_actual);
    end
  endtask

  task automatic test_ch2_five_up();
    int w;
    int hi2, hi_other;
    ch_sel = 2'd2;
    repeat (5) pulse(1'b1, 1'b0);
    checks++;
    if (duty_actual !== 4'd5) begin
      errors++;
      $display("FAIL ch2_duty: got %0d, expected 5", duty_actual);
    end
    wait_ps(40, w);
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL ch2_wait_ps: got timeout, expected period_start");
    end
    hi2 = 0; hi_other = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_100MHz);
      if (pwm_out[2]) hi2++;
      if ({pwm_out[3], pwm_out[1:0]} !== 3'b000) hi_other++;
    end
    checks++;
    if (hi2 !== 5) begin
      errors++;
      $display("FAIL ch2_high_cycles: got %0d, expected 5", hi2);
    end
    checks++;
    if (hi_other !== 0) begin
      errors++;
      $display("FAIL ch2_others_low: got %0d busy samples, expected 0", hi_other);
    end
  endtask

  task automatic test_saturate();
    int w;
    int hi0, hi2;
    ch_sel = 2'd0; wrap_mode = 1'b0;
    repeat (20) pulse(1'b1, 1'b0);
    checks++;
    if (duty_actual !== 4'd15) begin
      errors++;
      $display("FAIL sat_high: got %0d, expected 15", duty_actual);
    end
    wait_ps(40, w);
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL sat_wait_ps: got timeout, expected period_start");
    end
    hi0 = 0; hi2 = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_100MHz);
      if (pwm_out[0]) hi0++;
      if (pwm_out[2]) hi2++;
    end
    checks++;
    if (hi0 !== 15) begin
      errors++;
      $display("FAIL sat_always_high: got %0d, expected 15", hi0);
    end
    checks++;
    if (hi2 !== 5) begin
      errors++;
      $display("FAIL independence_ch2: got %0d, expected 5", hi2);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (duty_actual !== 4'd14) begin
      errors++;
      $display("FAIL sat_down: got %0d, expected 14", duty_actual);
    end
  endtask

  task automatic test_wrap();
    pulse(1'b1, 1'b0);
    checks++;
    if (duty_actual !== 4'd15) begin
      errors++;
      $display("FAIL wrap_setup: got %0d, expected 15", duty_actual);
    end
    wrap_mode = 1'b1;
    pulse(1'b1, 1'b0);
    checks++;
    if (duty_actual !== 4'd0) begin
      errors++;
      $display("FAIL wrap_up: got %0d, expected 0", duty_actual);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (duty_actual !== 4'd15) begin
      errors++;
      $display("FAIL wrap_down: got %0d, expected 15", duty_actual);
    end
    wrap_mode = 1'b0; ch_sel = 2'd1;
    pulse(1'b0, 1'b1);
    checks++;
    if (duty_actual !== 4'd0) begin
      errors++;
      $display("FAIL sat_low: got %0d, expected 0", duty_actual);
    end
  endtask

  task automatic test_discard();
    ch_sel = 2'd0; wrap_mode = 1'b1;
    pulse(1'b1, 1'b1);
    checks++;
    if (duty_actual !== 4'd15) begin
      errors++;
      $display("FAIL both_edges: got %0d, expected 15", duty_actual);
    end
    chip_select = 1'b0;
    pulse(1'b1, 1'b0);
    chip_select = 1'b1;
    checks++;
    if (duty_actual !== 4'd15) begin
      errors++;
      $display("FAIL chip_select_low: got %0d, expected 15", duty_actual);
    end
    wrap_mode = 1'b0;
    ch_sel = 2'd2; tick_n(1);
    checks++;
    if (duty_actual !== 4'd5) begin
      errors++;
      $display("FAIL independence_ch2_duty: got %0d, expected 5", duty_actual);
    end
  endtask

  task automatic test_shadow();
    int w;
    int hi_a0, hi_a, hi_b;
    ch_sel = 2'd3;
    repeat (3) pulse(1'b1, 1'b0);
    checks++;
    if (duty_actual !== 4'd3) begin
      errors++;
      $display("FAIL shadow_setup: got %0d, expected 3", duty_actual);
    end
    wait_ps(40, w);
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL shadow_wait_ps: got timeout, expected period_start");
    end
    // Seven one-cycle up pulses land duty_reg 4..10 inside the second period.
    hi_a0 = 0; hi_a = 0; hi_b = 0;
    for (int n = 0; n < 45; n++) begin
      up = (n >= 13 && n <= 25 && (n % 2) == 1);
      @(negedge clk_100MHz);
      if (pwm_out[3]) begin
        if (n < 15) hi_a0++;
        else if (n < 30) hi_a++;
        else hi_b++;
      end
      if (n == 14 || n == 29) begin
        checks++;
        if (period_start !== 1'b1) begin
          errors++;
          $display("FAIL shadow_period_start_%0d: got %b, expected 1", n, period_start);
        end
      end
    end
    up = 1'b0;
    checks++;
    if (hi_a0 !== 3 || hi_a !== 3) begin
      errors++;
      $display("FAIL shadow_old_period: got %0d/%0d, expected 3/3", hi_a0, hi_a);
    end
    checks++;
    if (hi_b !== 10) begin
      errors++;
      $display("FAIL shadow_new_period: got %0d, expected 10", hi_b);
    end
    checks++;
    if (duty_actual !== 4'd10) begin
      errors++;
      $display("FAIL shadow_duty: got %0d, expected 10", duty_actual);
    end
  endtask

  task automatic test_prescale();
    int w;
    ch_sel4 = 2'd1;
    repeat (2) pulse4_up();
    checks++;
    if (duty_actual4 !== 4'd2) begin
      errors++;
      $display("FAIL p4_duty: got %0d, expected 2", duty_actual4);
    end
    wait_ps4(200, w);
    checks++;
    if (w < 0) begin
      errors++;
      $display("FAIL p4_wait_ps: got timeout, expected period_start");
    end
    wait_ps4(200, w);
    checks++;
    if (w !== 60) begin
      errors++;
      $display("FAIL p4_period: got %0d cycles, expected 60", w);
    end
    tick_n(4);
    checks++;
    if (pwm_out4 !== 4'b0010) begin
      errors++;
      $display("FAIL p4_pwm_before_rst: got %b, expected 0010", pwm_out4);
    end
    rst4 = 1'b1;
    tick_n(1);
    checks++;
    if ({pwm_out4, duty_actual4, period_start4} !== 9'd0) begin
      errors++;
      $display("FAIL p4_mid_reset: got pwm=%b duty=%0d ps=%b, expected all 0", pwm_out4, duty_actual4, period_start4);
    end
    tick_n(1);
    rst4 = 1'b0;
    wait_ps4(200, w);
    checks++;
    if (w !== 60) begin
      errors++;
      $display("FAIL p4_restart: got %0d cycles, expected 60", w);
    end
    checks++;
    if (duty_actual4 !== 4'd0) begin
      errors++;
      $display("FAIL p4_duty_after_rst: got %0d, expected 0", duty_actual4);
    end
  endtask

  initial begin
    @(negedge clk_100MHz);
    test_reset();
    test_ch2_five_up();
    test_saturate();
    test_wrap();
    test_discard();
    test_shadow();
    test_prescale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
